// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-side signals shared by mem_port_arbiter and its users.
// slave = arbiter side; master = requesters plus the RAM that answers them.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [31:0]       d_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0]       conflict_cnt;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  ram_rdata,
        output if_gnt, if_valid, if_rdata,
        output d_gnt, d_valid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output conflict_cnt
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output ram_rdata,
        input  if_gnt, if_valid, if_rdata,
        input  d_gnt, d_valid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access.
// Data has priority; a starved fetch wins the next conflict. Read data returns one cycle after grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DR,
        OWN_DW
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

    owner_t      owner;
    logic [3:0]  starve_cnt;
    logic [31:0] conflict_cnt;

    logic fetch_wins;
    logic if_gnt;
    logic d_gnt;
    logic both_req;

    assign both_req   = bus.if_req & bus.d_req;
    assign fetch_wins = both_req & (starve_cnt == STARVE_LIM);
    assign d_gnt      = rst & bus.d_req & ~fetch_wins;
    assign if_gnt     = rst & bus.if_req & ~d_gnt;

    assign bus.if_gnt = if_gnt;
    assign bus.d_gnt  = d_gnt;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (d_gnt) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = bus.d_we ? bus.d_be : 4'b0000;
            bus.ram_addr  = bus.d_addr[ADDR_W+1:2];
            bus.ram_wdata = bus.d_wdata;
        end else if (if_gnt) begin
            bus.ram_en    = 1'b1;
            bus.ram_addr  = bus.if_addr[ADDR_W+1:2];
            bus.ram_wdata = bus.d_wdata;
        end
    end

    // Byte-offset and above-depth address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner        <= OWN_NONE;
            starve_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (if_gnt)
                owner <= OWN_IF;
            else if (d_gnt)
                owner <= bus.d_we ? OWN_DW : OWN_DR;
            else
                owner <= OWN_NONE;

            if (bus.if_req && !if_gnt) begin
                if (starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end

            if (both_req && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    assign bus.if_valid     = (owner == OWN_IF);
    assign bus.if_rdata     = (owner == OWN_IF) ? bus.ram_rdata : '0;
    assign bus.d_valid      = (owner == OWN_DR) || (owner == OWN_DW);
    assign bus.d_rdata      = (owner == OWN_DR) ? bus.ram_rdata : '0;
    assign bus.conflict_cnt = conflict_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected read data,
// a negedge monitor pops it whenever a valid response appears.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(10)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (10),
        .MAX_STARVE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    int n_vec  = 0;
    int n_miss = 0;

    // Synchronous RAM model; one-cycle read latency.
    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.ram_en) begin
            w = mem[bus.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) w[b*8 +: 8] = bus.ram_wdata[b*8 +: 8];
            mem[bus.ram_addr] = w;
            bus.ram_rdata <= w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.if_valid) begin
                if (exp_if.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL if_valid_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("if_rdata", bus.if_rdata, exp_if.pop_front());
                end
            end
            if (bus.d_valid) begin
                if (exp_d.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL d_valid_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("d_rdata", bus.d_rdata, exp_d.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] words [0:2];
        words[0] = 32'h11;
        words[1] = 32'h22;
        words[2] = 32'h33;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]     = 32'h11;
        mem[1]     = 32'h22;
        mem[2]     = 32'h33;
        mem[8]     = 32'h1234_5678;
        mem[10'h100] = 32'hCAFE_0100;

        // Reset held with both requests up
        rst         = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_be    = 4'h0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_if_gnt",   32'(bus.if_gnt), 32'd0);
        chk("rst_d_gnt",    32'(bus.d_gnt), 32'd0);
        chk("rst_ram_en",   32'(bus.ram_en), 32'd0);
        chk("rst_ram_we",   32'(bus.ram_we), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_d_valid",  32'(bus.d_valid), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata",  bus.d_rdata, 32'd0);
        chk("rst_conflict", bus.conflict_cnt, 32'd0);

        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_d_gnt",  32'(bus.d_gnt), 32'd1);
        chk("post_rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        exp_d.push_back(32'h11);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        // Fetch-only stream
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.if_req  = 1'b1;
            bus.if_addr = 32'(i * 4);
            @(negedge clk);
            chk("fetch_if_gnt",   32'(bus.if_gnt), 32'd1);
            chk("fetch_d_gnt",    32'(bus.d_gnt), 32'd0);
            chk("fetch_ram_en",   32'(bus.ram_en), 32'd1);
            chk("fetch_ram_addr", 32'(bus.ram_addr), 32'(i));
            exp_if.push_back(words[i]);
        end
        @(posedge clk); #1 bus.if_req = 1'b0;
        @(negedge clk);

        // Fresh reset so the conflict count starts from zero
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // Continuous conflict: data x4, fetch, data
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h8;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h4;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("prio_if_gnt", 32'(bus.if_gnt), (c == 4) ? 32'd1 : 32'd0);
            chk("prio_d_gnt",  32'(bus.d_gnt),  (c == 4) ? 32'd0 : 32'd1);
            if (c == 5) chk("prio_conflict", bus.conflict_cnt, 32'd5);
            if (c == 4) exp_if.push_back(32'h33);
            else        exp_d.push_back(32'h22);
            @(posedge clk); #1;
        end
        bus.if_req = 1'b0;

        // Partial write then read-back of the same word
        bus.d_we    = 1'b1;
        bus.d_be    = 4'b0011;
        bus.d_addr  = 32'h20;
        bus.d_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        chk("wr_d_gnt",     32'(bus.d_gnt), 32'd1);
        chk("wr_ram_we",    32'(bus.ram_we), 32'h3);
        chk("wr_ram_addr",  32'(bus.ram_addr), 32'h8);
        chk("wr_ram_wdata", bus.ram_wdata, 32'hAABB_CCDD);
        exp_d.push_back(32'h0);
        @(posedge clk); #1;
        bus.d_we    = 1'b0;
        bus.d_be    = 4'h0;
        bus.d_wdata = 32'h0;
        @(negedge clk);
        chk("rd_d_gnt",    32'(bus.d_gnt), 32'd1);
        chk("rd_ram_we",   32'(bus.ram_we), 32'd0);
        chk("rd_ram_addr", 32'(bus.ram_addr), 32'h8);
        exp_d.push_back(32'h1234_CCDD);

        // Address masking
        @(posedge clk); #1 bus.d_addr = 32'hFFFF_F403;
        @(negedge clk);
        chk("mask_ram_addr", 32'(bus.ram_addr), 32'h100);
        exp_d.push_back(32'hCAFE_0100);
        @(posedge clk); #1 bus.d_req = 1'b0;
        @(negedge clk);

        // Reset lands between a fetch grant and its response
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4;
        @(negedge clk);
        chk("midrd_if_gnt", 32'(bus.if_gnt), 32'd1);
        #1;
        rst        = 1'b0;
        bus.if_req = 1'b0;
        #1;
        chk("midrd_ram_en",   32'(bus.ram_en), 32'd0);
        chk("midrd_conflict", bus.conflict_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrd_if_valid", 32'(bus.if_valid), 32'd0);
        chk("midrd_conf_post", bus.conflict_cnt, 32'd0);

        // Starvation counter cleared: first conflict goes to data
        @(posedge clk); #1;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h4;
        @(negedge clk);
        chk("post_midrd_d_gnt", 32'(bus.d_gnt), 32'd1);
        exp_d.push_back(32'h22);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (2) @(negedge clk);

        chk("exp_if_drained", 32'(exp_if.size()), 32'd0);
        chk("exp_d_drained",  32'(exp_d.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the pipeline's instruction-fetch port and data-memory port.
- Replaces the separate inst_ram/data_ram instances.
- Issues at most one access per cycle: data port has priority, with an anti-starvation override for fetch.
- Returns read data one cycle after grant, tagged to the requester that owns it.

Parameters:
ADDR_W, 10, RAM word-address width (RAM depth = 2^ADDR_W words)
MAX_STARVE, 4, consecutive denied fetch cycles after which fetch wins the next conflict (range 1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
if_req  input  1  fetch request; held with if_addr stable until if_gnt
if_addr  input  32  fetch byte address
if_gnt  output  1  fetch granted this cycle (combinational)
if_valid  output  1  fetch read data valid (cycle after if_gnt)
if_rdata  output  32  fetch read data
d_req  input  1  data request; held with d_addr, d_we, d_be, d_wdata stable until d_gnt
d_we  input  1  1 = write, 0 = read
d_be  input  4  byte enables for a write
d_addr  input  32  data byte address
d_wdata  input  32  write data
d_gnt  output  1  data granted this cycle (combinational)
d_valid  output  1  data ack / read data valid (cycle after d_gnt, reads and writes)
d_rdata  output  32  data read data
ram_en  output  1  RAM enable
ram_we  output  4  RAM byte write enables
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid the cycle after a read is issued
conflict_cnt  output  32  count of cycles with if_req and d_req both high

Behaviour:
- Reset (rst low, asynchronous):
  - owner = NONE, starve_cnt = 0, conflict_cnt = 0.
  - if_valid = d_valid = 0; if_rdata = d_rdata = 0.
  - An outstanding read is discarded and no valid pulse follows reset release.
- Grant logic (combinational, only while rst high):
  - Only d_req: d_gnt = 1.
  - Only if_req: if_gnt = 1.
  - Both requesting: fetch wins if starve_cnt == MAX_STARVE; otherwise data wins.
  - At most one grant per cycle; no request gives no grant.
- RAM drive:
  - ram_en = if_gnt | d_gnt.
  - ram_addr = granted addr[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 are ignored.
  - ram_we = d_be when d_gnt & d_we, else 4'b0000.
  - ram_wdata = d_wdata.
  - With no grant: ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Owner FSM:
  - States: NONE, IF, DR (data read), DW (data write).
  - Next state from this cycle's grant: if_gnt goes to IF; d_gnt & ~d_we goes to DR; d_gnt & d_we goes to DW; no grant goes to NONE.
  - Every state is left after one cycle, so back-to-back grants pipeline fully (throughput 1 access/cycle).
- Responses (combinational from owner):
  - IF: if_valid = 1, if_rdata = ram_rdata.
  - DR: d_valid = 1, d_rdata = ram_rdata.
  - DW: d_valid = 1, d_rdata = 0.
  - Any *_rdata not currently valid is driven 0.
- Starvation counter:
  - if_req & ~if_gnt: starve_cnt increments, saturating at MAX_STARVE.
  - if_gnt or ~if_req: starve_cnt resets to 0.
  - A fetch override grant therefore clears it.
- conflict_cnt increments when if_req & d_req; saturates at 32'hFFFFFFFF.
- Simultaneous events:
  - A new grant in the same cycle as a previous read's response is legal; response and issue are independent.
  - A request deasserted before grant is dropped silently.
- Read-after-write to the same address on consecutive grants returns the new data; the RAM is write-first or the read is one cycle later by construction.
- Requesters may change address only on the cycle after their grant.

Test Plan:
- Reset: hold rst low with both requests high → all outputs 0, no RAM enable; release → first cycle grants data (d_gnt=1, if_gnt=0).
- Fetch-only stream: if_req=1, if_addr 0x0,0x4,0x8 on consecutive cycles, RAM preloaded words 0..2 = 0x11,0x22,0x33 → if_gnt=1 each cycle, if_valid=1 with if_rdata 0x11,0x22,0x33 one cycle later, ram_addr 0,1,2.
- Conflict / priority: both request continuously, MAX_STARVE=4 → d_gnt for 4 cycles, if_gnt on the 5th, then data again; conflict_cnt=5 after 5 cycles.
- Write then read: d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0xAABBCCDD over 0x12345678, then read 0x20 → ram_we=0011 on write, d_valid ack next cycle with d_rdata=0; read returns 0x1234CCDD.
- Reset mid-read: grant fetch read, assert rst low before the next edge → no if_valid after release; owner NONE; starve_cnt and conflict_cnt 0.
- Address masking: d_addr=0xFFFF_F403 with ADDR_W=10 → ram_addr=10'h100.
